// File: rtl/hazard_tag_pipe_pkg.sv
// Shared stage-record layout, bubble constant and T_new helpers for hazard_tag_pipe.
package hazard_tag_pipe_pkg;

   localparam int REG_W  = 5;
   localparam int TNEW_W = 2;

   // T_new encodings as seen on entry to E
   localparam logic [TNEW_W-1:0] T_NEW_NONE = 2'd0;
   localparam logic [TNEW_W-1:0] T_NEW_ALU  = 2'd1;
   localparam logic [TNEW_W-1:0] T_NEW_LOAD = 2'd2;

   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  wreg;
      logic [TNEW_W-1:0] t_new;
      logic              grf_we;
      logic              is_lw;
      logic              is_sw;
      logic              valid;
   } tag_rec_t;

   localparam tag_rec_t TAG_BUBBLE = '0;

   function automatic logic [TNEW_W-1:0] satdec(input logic [TNEW_W-1:0] x);
      return (x == '0) ? '0 : x - TNEW_W'(1);
   endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline stage register for a hazard tag record.
// Optional bubble injection on entry and saturating T_new decrement while advancing.
module hazard_tag_stage
   import hazard_tag_pipe_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  tag_rec_t rec_in,
   input  logic     bubble,
   input  logic     dec_en,
   output tag_rec_t rec_out
);

   tag_rec_t rec_nxt;

   // Bubble select wins so unknown inputs never reach the register
   always_comb begin
      rec_nxt = rec_in;
      if (dec_en) begin
         rec_nxt.t_new = satdec(rec_in.t_new);
      end
      if (bubble) begin
         rec_nxt = TAG_BUBBLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rec_out <= TAG_BUBBLE;
      end else begin
         rec_out <= rec_nxt;
      end
   end

endmodule

// File: rtl/hazard_tag_pipe.sv
// Carries per-instruction hazard tags through E, M and W for the stall/forwarding controller.
// All outputs registered; stall freezes D upstream and injects a bubble into E; also keeps statistics.
module hazard_tag_pipe #(
   parameter int TNEW_W = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              D_valid,
   input  logic [4:0]        D_rs,
   input  logic [4:0]        D_rt,
   input  logic [4:0]        D_Wreg,
   input  logic              D_GRF_WE,
   input  logic              D_is_LW,
   input  logic              D_is_SW,
   input  logic [TNEW_W-1:0] D_T_new_E,
   output logic [4:0]        E_rs,
   output logic [4:0]        E_rt,
   output logic [4:0]        E_Wreg,
   output logic [TNEW_W-1:0] E_T_new,
   output logic              E_GRF_WE,
   output logic              E_is_LW,
   output logic              E_is_SW,
   output logic              E_valid,
   output logic [4:0]        M_rs,
   output logic [4:0]        M_rt,
   output logic [4:0]        M_Wreg,
   output logic [TNEW_W-1:0] M_T_new,
   output logic              M_GRF_WE,
   output logic              M_is_LW,
   output logic              M_is_SW,
   output logic              M_valid,
   output logic [4:0]        W_rs,
   output logic [4:0]        W_rt,
   output logic [4:0]        W_Wreg,
   output logic [TNEW_W-1:0] W_T_new,
   output logic              W_GRF_WE,
   output logic              W_is_LW,
   output logic              W_valid,
   output logic [CNT_W-1:0]  cnt_cycle,
   output logic [CNT_W-1:0]  cnt_stall,
   output logic [CNT_W-1:0]  cnt_retire
);

   import hazard_tag_pipe_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   tag_rec_t d_rec;
   tag_rec_t e_rec;
   tag_rec_t m_rec;
   tag_rec_t w_rec;
   logic     e_bubble;
   logic     d_writes;
   logic     w_unused_sw;

   // A write to $0 is folded into "no write" so it can never match a source
   assign d_writes = D_GRF_WE && (D_Wreg != 5'd0);
   assign e_bubble = stall || !D_valid;

   always_comb begin
      d_rec        = TAG_BUBBLE;
      d_rec.rs     = D_rs;
      d_rec.rt     = D_rt;
      d_rec.wreg   = d_writes ? D_Wreg : 5'd0;
      d_rec.t_new  = D_T_new_E;
      d_rec.grf_we = d_writes;
      d_rec.is_lw  = D_is_LW;
      d_rec.is_sw  = D_is_SW;
      d_rec.valid  = 1'b1;
   end

   hazard_tag_stage u_stage_e (
      .clk     (clk),
      .reset   (reset),
      .rec_in  (d_rec),
      .bubble  (e_bubble),
      .dec_en  (1'b0),
      .rec_out (e_rec)
   );

   hazard_tag_stage u_stage_m (
      .clk     (clk),
      .reset   (reset),
      .rec_in  (e_rec),
      .bubble  (1'b0),
      .dec_en  (1'b1),
      .rec_out (m_rec)
   );

   hazard_tag_stage u_stage_w (
      .clk     (clk),
      .reset   (reset),
      .rec_in  (m_rec),
      .bubble  (1'b0),
      .dec_en  (1'b1),
      .rec_out (w_rec)
   );

   assign E_rs     = e_rec.rs;
   assign E_rt     = e_rec.rt;
   assign E_Wreg   = e_rec.wreg;
   assign E_T_new  = e_rec.t_new;
   assign E_GRF_WE = e_rec.grf_we;
   assign E_is_LW  = e_rec.is_lw;
   assign E_is_SW  = e_rec.is_sw;
   assign E_valid  = e_rec.valid;

   assign M_rs     = m_rec.rs;
   assign M_rt     = m_rec.rt;
   assign M_Wreg   = m_rec.wreg;
   assign M_T_new  = m_rec.t_new;
   assign M_GRF_WE = m_rec.grf_we;
   assign M_is_LW  = m_rec.is_lw;
   assign M_is_SW  = m_rec.is_sw;
   assign M_valid  = m_rec.valid;

   assign W_rs     = w_rec.rs;
   assign W_rt     = w_rec.rt;
   assign W_Wreg   = w_rec.wreg;
   assign W_T_new  = w_rec.t_new;
   assign W_GRF_WE = w_rec.grf_we;
   assign W_is_LW  = w_rec.is_lw;
   assign W_valid  = w_rec.valid;
   // Stores never write back, so W has no use for the store flag
   assign w_unused_sw = w_rec.is_sw;

   // Retirement is counted on the edge where the W occupant leaves
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_cycle  <= CNT_ZERO;
         cnt_stall  <= CNT_ZERO;
         cnt_retire <= CNT_ZERO;
      end else begin
         cnt_cycle  <= cnt_cycle + {{(CNT_W-1){1'b0}}, 1'b1};
         cnt_stall  <= cnt_stall + {{(CNT_W-1){1'b0}}, stall};
         cnt_retire <= cnt_retire + {{(CNT_W-1){1'b0}}, w_rec.valid};
      end
   end

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Scoreboard bench for hazard_tag_pipe: history-based reference model, directed and random stimulus.
module tb_hazard_tag_pipe;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic          D_valid = 1'b0;
   logic [4:0]    D_rs = '0, D_rt = '0, D_Wreg = '0;
   logic          D_GRF_WE = 1'b0, D_is_LW = 1'b0, D_is_SW = 1'b0;
   logic [1:0]    D_T_new_E = '0;
   logic [4:0]    E_rs, E_rt, E_Wreg, M_rs, M_rt, M_Wreg, W_rs, W_rt, W_Wreg;
   logic [1:0]    E_T_new, M_T_new, W_T_new;
   logic          E_GRF_WE, E_is_LW, E_is_SW, E_valid;
   logic          M_GRF_WE, M_is_LW, M_is_SW, M_valid;
   logic          W_GRF_WE, W_is_LW, W_valid;
   logic [CW-1:0] cnt_cycle, cnt_stall, cnt_retire;

   hazard_tag_pipe #(.TNEW_W(2), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .D_valid(D_valid),
      .D_rs(D_rs), .D_rt(D_rt), .D_Wreg(D_Wreg), .D_GRF_WE(D_GRF_WE),
      .D_is_LW(D_is_LW), .D_is_SW(D_is_SW), .D_T_new_E(D_T_new_E),
      .E_rs(E_rs), .E_rt(E_rt), .E_Wreg(E_Wreg), .E_T_new(E_T_new),
      .E_GRF_WE(E_GRF_WE), .E_is_LW(E_is_LW), .E_is_SW(E_is_SW), .E_valid(E_valid),
      .M_rs(M_rs), .M_rt(M_rt), .M_Wreg(M_Wreg), .M_T_new(M_T_new),
      .M_GRF_WE(M_GRF_WE), .M_is_LW(M_is_LW), .M_is_SW(M_is_SW), .M_valid(M_valid),
      .W_rs(W_rs), .W_rt(W_rt), .W_Wreg(W_Wreg), .W_T_new(W_T_new),
      .W_GRF_WE(W_GRF_WE), .W_is_LW(W_is_LW), .W_valid(W_valid),
      .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_retire(cnt_retire)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs, rt, wr;
      logic [1:0] tn;
      logic       we, lw, sw, v;
   } trec_t;

   typedef struct {
      trec_t e, m, w;
      int    cyc, stl, ret;
   } exp_t;

   exp_t  sbq[$];
   trec_t hist[3];      // hist[k] = record that entered E k edges ago
   int    m_cyc, m_stl, m_ret;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic trec_t age(input trec_t r, input int k);
      trec_t o = r;
      o.tn = (int'(r.tn) > k) ? 2'(int'(r.tn) - k) : 2'd0;
      return o;
   endfunction

   function automatic trec_t act_e();
      return '{E_rs, E_rt, E_Wreg, E_T_new, E_GRF_WE, E_is_LW, E_is_SW, E_valid};
   endfunction
   function automatic trec_t act_m();
      return '{M_rs, M_rt, M_Wreg, M_T_new, M_GRF_WE, M_is_LW, M_is_SW, M_valid};
   endfunction
   function automatic trec_t act_w();
      return '{W_rs, W_rt, W_Wreg, W_T_new, W_GRF_WE, W_is_LW, 1'b0, W_valid};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_cyc = 0; m_stl = 0; m_ret = 0;
   endtask

   // Apply one cycle of D-side stimulus and queue what the pipe must show after the edge
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic we, input logic lw, input logic sw,
                        input logic [1:0] tn, input logic st);
      trec_t ent;
      exp_t  x;
      @(negedge clk);
      D_valid = v; D_rs = rs; D_rt = rt; D_Wreg = wr; D_GRF_WE = we;
      D_is_LW = lw; D_is_SW = sw; D_T_new_E = tn; stall = st;
      ent = '0;
      if (v && !st) begin
         ent = '{rs, rt, (we && wr != 0) ? wr : 5'd0, tn, we && wr != 0, lw, sw, 1'b1};
      end
      m_ret += int'(hist[2].v);
      m_cyc++;
      m_stl += int'(st);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = ent;
      x.e = hist[0];
      x.m = age(hist[1], 1);
      x.w = age(hist[2], 2);
      x.w.sw = 1'b0;
      x.cyc = m_cyc; x.stl = m_stl; x.ret = m_ret;
      sbq.push_back(x);
   endtask

   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_E"}, 32'(act_e()), 32'd0);
      chk({nm, "_M"}, 32'(act_m()), 32'd0);
      chk({nm, "_W"}, 32'(act_w()), 32'd0);
      chk({nm, "_cnt"}, 32'({cnt_cycle, cnt_stall, cnt_retire}), 32'd0);
   endtask

   // Monitor: compare every post-edge output set against the oldest queued expectation
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (!reset && sbq.size() > 0) begin
         x = sbq.pop_front();
         chk("E_stage", 32'(act_e()), 32'(x.e));
         chk("M_stage", 32'(act_m()), 32'(x.m));
         chk("W_stage", 32'(act_w()), 32'(x.w));
         chk("counters", 32'({cnt_cycle, cnt_stall, cnt_retire}),
             32'({4'(x.cyc), 4'(x.stl), 4'(x.ret)}));
      end
   end

   initial begin
      model_reset();
      #3;
      check_all_zero("reset_init");
      @(posedge clk); #2;
      reset = 1'b0;

      // Load through all stages, then retirement
      drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      bubble(4);

      // Load followed by a dependent instruction stalled one cycle
      drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
      drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
      bubble(3);

      // $0 / no-write sanitising, store, invalid with all-ones tags
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
      drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
      drive(1'b1, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      drive(1'b0, 5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
      bubble(3);

      // Random traffic; long enough for every 4-bit counter to wrap several times
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(3, 0) != 0, 5'($urandom), 5'($urandom),
               ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(3, 0) == 0);
      end

      // Fill all stages, then pulse reset between edges
      for (int i = 0; i < 3; i++)
         drive(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
      @(negedge clk);
      chk("full_before_reset", 32'({E_valid, M_valid, W_valid}), 32'd7);
      reset = 1'b1;
      #1;
      check_all_zero("reset_mid");
      @(posedge clk); #2;
      reset = 1'b0;
      model_reset();
      drive(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      bubble(20);

      @(posedge clk); #2;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
